// File: rtl/div_share_ctrl_pkg.sv
// Shared types and constants for the dual-lane divider arbiter and its iterative core.
package div_share_ctrl_pkg;

    localparam int XLEN             = 32;
    localparam int ITER             = XLEN;
    localparam int CNT_W            = $clog2(ITER);
    localparam int ES_TO_DIV_BUS_MD = 3 + 2 * XLEN;
    localparam int DIV_TO_ES_BUS_MD = XLEN + 1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    // Field order matches the es_to_div_bus layout exactly.
    typedef struct packed {
        logic            valid;
        logic            use_mod;
        logic            is_unsigned;
        logic [XLEN-1:0] src1;
        logic [XLEN-1:0] src2;
    } es_req_t;

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic n);
        logic [XLEN-1:0] r;
        if (n) begin
            r = {XLEN{1'b0}} - v;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/div_share_ctrl_div_core.sv
// Unsigned restoring divider, one quotient bit per cycle; done marks the final step,
// with q/r presenting that step's results combinationally.
module div_core
    import div_share_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            clr,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] q,
    output logic [XLEN-1:0] r,
    output logic            done
);

    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  div_q, div_d;
    logic [XLEN:0]    shifted_s;
    logic             ge_s;
    logic [XLEN-1:0]  quo_nxt_s, rem_nxt_s;
    logic             last_s;

    // Single restoring step plus load/abort sequencing.
    always_comb begin
        shifted_s = {rem_q, quo_q[XLEN-1]};
        ge_s      = (shifted_s >= {1'b0, div_q});
        if (ge_s) begin
            rem_nxt_s = XLEN'(shifted_s - {1'b0, div_q});
        end else begin
            rem_nxt_s = shifted_s[XLEN-1:0];
        end
        quo_nxt_s = {quo_q[XLEN-2:0], ge_s};
        last_s    = busy_q && (cnt_q == CNT_W'(ITER - 1));

        busy_d = busy_q;
        cnt_d  = cnt_q;
        quo_d  = quo_q;
        rem_d  = rem_q;
        div_d  = div_q;
        if (clr) begin
            busy_d = 1'b0;
            cnt_d  = {CNT_W{1'b0}};
        end else if (start) begin
            busy_d = 1'b1;
            cnt_d  = {CNT_W{1'b0}};
            quo_d  = a;
            rem_d  = {XLEN{1'b0}};
            div_d  = b;
        end else if (busy_q) begin
            quo_d  = quo_nxt_s;
            rem_d  = rem_nxt_s;
            cnt_d  = cnt_q + CNT_W'(1);
            busy_d = ~last_s;
        end else begin
            busy_d = 1'b0;
        end
    end

    assign q    = quo_nxt_s;
    assign r    = rem_nxt_s;
    assign done = last_s && !clr;

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
            cnt_q  <= {CNT_W{1'b0}};
            quo_q  <= {XLEN{1'b0}};
            rem_q  <= {XLEN{1'b0}};
            div_q  <= {XLEN{1'b0}};
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            div_q  <= div_d;
        end
    end

endmodule

// File: rtl/div_share_ctrl.sv
// Arbitrates one shared divider between two EXM lanes (lane 0 first), applies sign fixes,
// and holds each lane's result with div_ok until that lane's instruction advances.
module div_share_ctrl
    import div_share_ctrl_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush_ES,
    input  logic [ES_TO_DIV_BUS_MD-1:0] es0_to_div_bus,
    input  logic [ES_TO_DIV_BUS_MD-1:0] es1_to_div_bus,
    input  logic [1:0]                  lane_adv,
    output logic [DIV_TO_ES_BUS_MD-1:0] div0_to_es_bus,
    output logic [DIV_TO_ES_BUS_MD-1:0] div1_to_es_bus,
    output logic                        div_busy
);

    es_req_t         req0_s, req1_s, sel_s, own_s;
    state_e          state_q, state_d;
    logic            owner_q, owner_d;
    logic [1:0]      done_q, done_d;
    logic [XLEN-1:0] res0_q, res0_d, res1_q, res1_d;
    logic            use_mod_q, use_mod_d;
    logic            q_neg_q, q_neg_d, r_neg_q, r_neg_d, dz_q, dz_d;
    logic            busy_q, busy_d;
    logic            want0_s, want1_s;
    logic            start_s, clr_s;
    logic [XLEN-1:0] a_s, b_s, q_s, r_s, result_s;
    logic            core_done_s;

    assign req0_s = es_req_t'(es0_to_div_bus);
    assign req1_s = es_req_t'(es1_to_div_bus);

    div_core u_div_core (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_s),
        .start (start_s),
        .a     (a_s),
        .b     (b_s),
        .q     (q_s),
        .r     (r_s),
        .done  (core_done_s)
    );

    // Arbitration, completion capture, per-lane hold and flush handling.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        done_d    = done_q;
        res0_d    = res0_q;
        res1_d    = res1_q;
        use_mod_d = use_mod_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        dz_d      = dz_q;
        start_s   = 1'b0;
        clr_s     = 1'b0;

        // A lane that already holds a result must not be regranted until it advances.
        want0_s = req0_s.valid && !done_q[0];
        want1_s = req1_s.valid && !done_q[1];
        sel_s   = want0_s ? req0_s : req1_s;
        own_s   = owner_q ? req1_s : req0_s;
        a_s     = cond_neg(sel_s.src1, !sel_s.is_unsigned && sel_s.src1[XLEN-1]);
        b_s     = cond_neg(sel_s.src2, !sel_s.is_unsigned && sel_s.src2[XLEN-1]);

        if (use_mod_q) begin
            result_s = cond_neg(r_s, r_neg_q);
        end else if (dz_q) begin
            result_s = {XLEN{1'b1}};
        end else begin
            result_s = cond_neg(q_s, q_neg_q);
        end

        if (lane_adv[0] && done_q[0]) begin
            done_d[0] = 1'b0;
            res0_d    = {XLEN{1'b0}};
        end else begin
            done_d[0] = done_q[0];
        end
        if (lane_adv[1] && done_q[1]) begin
            done_d[1] = 1'b0;
            res1_d    = {XLEN{1'b0}};
        end else begin
            done_d[1] = done_q[1];
        end

        case (state_q)
            S_IDLE: begin
                if (want0_s || want1_s) begin
                    start_s   = 1'b1;
                    owner_d   = !want0_s;
                    use_mod_d = sel_s.use_mod;
                    dz_d      = (sel_s.src2 == {XLEN{1'b0}});
                    q_neg_d   = !sel_s.is_unsigned && (sel_s.src1[XLEN-1] ^ sel_s.src2[XLEN-1]);
                    r_neg_d   = !sel_s.is_unsigned && sel_s.src1[XLEN-1];
                    state_d   = S_BUSY;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                if (!own_s.valid) begin
                    clr_s   = 1'b1;
                    state_d = S_IDLE;
                end else if (core_done_s) begin
                    done_d[owner_q] = 1'b1;
                    if (owner_q) begin
                        res1_d = result_s;
                    end else begin
                        res0_d = result_s;
                    end
                    state_d = S_IDLE;
                end else begin
                    state_d = S_BUSY;
                end
            end
            default: begin
                clr_s   = 1'b1;
                state_d = S_IDLE;
            end
        endcase

        if (flush_ES) begin
            state_d = S_IDLE;
            owner_d = 1'b0;
            done_d  = 2'b00;
            res0_d  = {XLEN{1'b0}};
            res1_d  = {XLEN{1'b0}};
            start_s = 1'b0;
            clr_s   = 1'b1;
        end else begin
            clr_s = clr_s;
        end

        busy_d = (state_d == S_BUSY);
    end

    // FSM and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            owner_q   <= 1'b0;
            done_q    <= 2'b00;
            res0_q    <= {XLEN{1'b0}};
            res1_q    <= {XLEN{1'b0}};
            use_mod_q <= 1'b0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            dz_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            done_q    <= done_d;
            res0_q    <= res0_d;
            res1_q    <= res1_d;
            use_mod_q <= use_mod_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            dz_q      <= dz_d;
            busy_q    <= busy_d;
        end
    end

    assign div0_to_es_bus = {res0_q, done_q[0]};
    assign div1_to_es_bus = {res1_q, done_q[1]};
    assign div_busy       = busy_q;

endmodule
